// File: rtl/read_addr_sched.sv
// Round-robin scheduler granting one of three AXI read masters a single outstanding AR request.
// Optional DATA-phase watchdog is compiled in with READ_ARB_TIMEOUT_EN.
module read_addr_sched #(
    parameter int ID_W    = 4,
    parameter int IDS_W   = 8,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 4,
    parameter int SIZE_W  = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   ARID_M0,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [LEN_W-1:0]  ARLEN_M0,
    input  logic [SIZE_W-1:0] ARSIZE_M0,
    input  logic [1:0]        ARBURST_M0,
    input  logic              ARVALID_M0,
    output logic              ARREADY_M0,
    input  logic [ID_W-1:0]   ARID_M1,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [LEN_W-1:0]  ARLEN_M1,
    input  logic [SIZE_W-1:0] ARSIZE_M1,
    input  logic [1:0]        ARBURST_M1,
    input  logic              ARVALID_M1,
    output logic              ARREADY_M1,
    input  logic [ID_W-1:0]   ARID_M2,
    input  logic [ADDR_W-1:0] ARADDR_M2,
    input  logic [LEN_W-1:0]  ARLEN_M2,
    input  logic [SIZE_W-1:0] ARSIZE_M2,
    input  logic [1:0]        ARBURST_M2,
    input  logic              ARVALID_M2,
    output logic              ARREADY_M2,
    output logic [IDS_W-1:0]  ARID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [LEN_W-1:0]  ARLEN_S,
    output logic [SIZE_W-1:0] ARSIZE_S,
    output logic [1:0]        ARBURST_S,
    output logic              ARVALID_S,
    input  logic              ARREADY_S,
    input  logic [IDS_W-1:0]  RID_S,
    input  logic              RVALID_S,
    input  logic              RREADY_S,
    input  logic              RLAST_S,
    output logic [2:0]        grant,
    output logic              timeout
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam int IDX_W = IDS_W - ID_W;

    logic [1:0] state;
    logic [1:0] ptr;
    logic [1:0] win;
    logic [1:0] sel;
    logic [1:0] c0, c1, c2;
    logic [3:0] req;
    logic       found;
    logic       accept;
    logic       done;
    logic       to_hit;

    logic [ID_W-1:0]   m_id;
    logic [ADDR_W-1:0] m_addr;
    logic [LEN_W-1:0]  m_len;
    logic [SIZE_W-1:0] m_size;
    logic [1:0]        m_burst;

    // Search order ptr, ptr+1, ptr+2 (mod 3); bit 3 pads the vector so any 2-bit index is legal.
    assign req = {1'b0, ARVALID_M2, ARVALID_M1, ARVALID_M0};
    assign c0  = ptr;
    assign c1  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    assign c2  = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;

    always_comb begin
        found = 1'b1;
        sel   = c0;
        if (req[c0])      sel = c0;
        else if (req[c1]) sel = c1;
        else if (req[c2]) sel = c2;
        else              found = 1'b0;
    end

    // Gated by rst so no master sees a handshake while reset is held.
    assign accept     = rst && (state == IDLE) && found;
    assign ARREADY_M0 = accept && (sel == 2'd0);
    assign ARREADY_M1 = accept && (sel == 2'd1);
    assign ARREADY_M2 = accept && (sel == 2'd2);

    always_comb begin
        m_id    = ARID_M0;
        m_addr  = ARADDR_M0;
        m_len   = ARLEN_M0;
        m_size  = ARSIZE_M0;
        m_burst = ARBURST_M0;
        case (sel)
            2'd1: begin
                m_id    = ARID_M1;
                m_addr  = ARADDR_M1;
                m_len   = ARLEN_M1;
                m_size  = ARSIZE_M1;
                m_burst = ARBURST_M1;
            end
            2'd2: begin
                m_id    = ARID_M2;
                m_addr  = ARADDR_M2;
                m_len   = ARLEN_M2;
                m_size  = ARSIZE_M2;
                m_burst = ARBURST_M2;
            end
            default: ;
        endcase
    end

    assign done = RVALID_S && RREADY_S && RLAST_S &&
                  (RID_S[IDS_W-1:ID_W] == IDX_W'(win));

    logic unused_rid;
    assign unused_rid = ^RID_S[ID_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            win       <= 2'd0;
            grant     <= 3'b000;
            ARVALID_S <= 1'b0;
            ARID_S    <= '0;
            ARADDR_S  <= '0;
            ARLEN_S   <= '0;
            ARSIZE_S  <= '0;
            ARBURST_S <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= ADDR;
                        win       <= sel;
                        grant     <= 3'b001 << sel;
                        ARVALID_S <= 1'b1;
                        ARID_S    <= {IDX_W'(sel), m_id};
                        ARADDR_S  <= m_addr;
                        ARLEN_S   <= m_len;
                        ARSIZE_S  <= m_size;
                        ARBURST_S <= m_burst;
                    end
                end
                ADDR: begin
                    if (ARREADY_S) begin
                        ARVALID_S <= 1'b0;
                        ptr       <= (win == 2'd2) ? 2'd0 : win + 2'd1;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (done || to_hit) begin
                        state <= IDLE;
                        grant <= 3'b000;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef READ_ARB_TIMEOUT_EN
    // cnt holds the number of DATA cycles already spent; it sits at zero outside DATA.
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                cnt <= 16'd0;
        else if (state != DATA)  cnt <= 16'd0;
        else                     cnt <= cnt + 16'd1;
    end

    assign to_hit  = (state == DATA) && !done && (cnt == 16'(TIMEOUT - 1));
    assign timeout = to_hit;
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_read_addr_sched.sv
// Randomized bench for read_addr_sched against a transaction-level round-robin model.
module tb_read_addr_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  ARID_M0, ARID_M1, ARID_M2;
    logic [31:0] ARADDR_M0, ARADDR_M1, ARADDR_M2;
    logic [3:0]  ARLEN_M0, ARLEN_M1, ARLEN_M2;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1, ARSIZE_M2;
    logic [1:0]  ARBURST_M0, ARBURST_M1, ARBURST_M2;
    logic        ARVALID_M0, ARVALID_M1, ARVALID_M2;
    logic        ARREADY_M0, ARREADY_M1, ARREADY_M2;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic [7:0]  RID_S;
    logic        RVALID_S, RREADY_S, RLAST_S;
    logic [2:0]  grant;
    logic        timeout;

    read_addr_sched dut (
        .clk(clk), .rst(rst),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
        .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .ARID_M2(ARID_M2), .ARADDR_M2(ARADDR_M2), .ARLEN_M2(ARLEN_M2), .ARSIZE_M2(ARSIZE_M2),
        .ARBURST_M2(ARBURST_M2), .ARVALID_M2(ARVALID_M2), .ARREADY_M2(ARREADY_M2),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S),
        .grant(grant), .timeout(timeout)
    );

    int checks = 0;
    int errors = 0;

    // Model state: pending master requests and the round-robin pointer.
    bit          req[3];
    logic [3:0]  id[3];
    logic [31:0] addr[3];
    logic [3:0]  len[3];
    logic [2:0]  size[3];
    logic [1:0]  burst[3];
    int          ptr_m = 0;
    bit          persist = 1'b0;
    int          force_rid = -1;
    logic [2:0]  got_grant;

    task automatic apply();
        ARVALID_M0 = req[0]; ARID_M0 = id[0]; ARADDR_M0 = addr[0];
        ARLEN_M0 = len[0]; ARSIZE_M0 = size[0]; ARBURST_M0 = burst[0];
        ARVALID_M1 = req[1]; ARID_M1 = id[1]; ARADDR_M1 = addr[1];
        ARLEN_M1 = len[1]; ARSIZE_M1 = size[1]; ARBURST_M1 = burst[1];
        ARVALID_M2 = req[2]; ARID_M2 = id[2]; ARADDR_M2 = addr[2];
        ARLEN_M2 = len[2]; ARSIZE_M2 = size[2]; ARBURST_M2 = burst[2];
    endtask

    task automatic new_payload(input int n);
        id[n]    = 4'($urandom);
        addr[n]  = $urandom;
        len[n]   = 4'($urandom);
        size[n]  = 3'($urandom);
        burst[n] = 2'($urandom);
    endtask

    function automatic int exp_winner();
        for (int k = 0; k < 3; k++) begin
            if (req[(ptr_m + k) % 3]) return (ptr_m + k) % 3;
        end
        return -1;
    endfunction

    // One full transaction starting in IDLE: grant, AR handshake after `hold` stall
    // cycles, `noise` non-completing R cycles, then the matching RLAST.
    task automatic do_txn(input int hold, input int noise);
        int w;
        logic [48:0] e_pay;
        logic [2:0]  e_gnt;
        w = exp_winner();
        apply();
        #1;
        checks++;
        if (w < 0) begin
            errors++;
            $display("FAIL txn_setup: no requester pending, model winner %0d", w);
            return;
        end
        e_gnt = 3'(1 << w);
        e_pay = {4'(w), id[w], addr[w], len[w], size[w], burst[w]};
        if ({ARREADY_M2, ARREADY_M1, ARREADY_M0} !== e_gnt) begin
            errors++;
            $display("FAIL arready_idle: got %b exp %b", {ARREADY_M2, ARREADY_M1, ARREADY_M0}, e_gnt);
        end
        checks++;
        if (grant !== 3'b000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL idle_grant: got grant %b timeout %b exp 000/0", grant, timeout);
        end
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            if (n == w) begin
                req[n] = persist ? 1'b1 : ($urandom_range(0, 2) == 0);
                new_payload(n);
            end else if (!persist && req[n] && $urandom_range(0, 3) == 0) begin
                req[n] = 1'b0;
            end else if (!persist && !req[n] && $urandom_range(0, 2) == 0) begin
                req[n] = 1'b1;
                new_payload(n);
            end
        end
        apply();
        got_grant = grant;
        for (int i = 0; i <= hold; i++) begin
            ARREADY_S = (i == hold);
            #1;
            checks++;
            if (ARVALID_S !== 1'b1 || {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} !== e_pay) begin
                errors++;
                $display("FAIL addr_phase: valid %b payload %h exp 1 %h", ARVALID_S,
                         {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S}, e_pay);
            end
            checks++;
            if (grant !== e_gnt || {ARREADY_M2, ARREADY_M1, ARREADY_M0} !== 3'b000) begin
                errors++;
                $display("FAIL addr_grant: grant %b arready %b exp %b 000", grant,
                         {ARREADY_M2, ARREADY_M1, ARREADY_M0}, e_gnt);
            end
            @(negedge clk);
        end
        ARREADY_S = 1'b0;
        ptr_m = (w + 1) % 3;
        #1;
        checks++;
        if (ARVALID_S !== 1'b0 || grant !== e_gnt) begin
            errors++;
            $display("FAIL data_entry: valid %b grant %b exp 0 %b", ARVALID_S, grant, e_gnt);
        end
        for (int i = 0; i < noise; i++) begin
            if (i == 0 && force_rid >= 0) begin
                RID_S = 8'(force_rid);
                RVALID_S = 1'b1; RREADY_S = 1'b1; RLAST_S = 1'b1;
            end else begin
                RID_S = 8'($urandom);
                RVALID_S = 1'($urandom); RREADY_S = 1'($urandom); RLAST_S = 1'($urandom);
                if (RVALID_S && RREADY_S && RLAST_S && RID_S[7:4] == 4'(w)) RLAST_S = 1'b0;
            end
            #1;
            checks++;
            if ({ARREADY_M2, ARREADY_M1, ARREADY_M0} !== 3'b000) begin
                errors++;
                $display("FAIL data_arready: got %b exp 000", {ARREADY_M2, ARREADY_M1, ARREADY_M0});
            end
            @(negedge clk);
            RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
            #1;
            checks++;
            if (grant !== e_gnt || timeout !== 1'b0) begin
                errors++;
                $display("FAIL data_hold: grant %b timeout %b exp %b 0", grant, timeout, e_gnt);
            end
        end
        RID_S = {4'(w), 4'($urandom)};
        RVALID_S = 1'b1; RREADY_S = 1'b1; RLAST_S = 1'b1;
        #1;
        checks++;
        if ({ARREADY_M2, ARREADY_M1, ARREADY_M0} !== 3'b000) begin
            errors++;
            $display("FAIL rlast_arready: got %b exp 000", {ARREADY_M2, ARREADY_M1, ARREADY_M0});
        end
        @(negedge clk);
        RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
        #1;
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("FAIL complete: grant %b exp 000", grant);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            req[n] = 1'b1;
            new_payload(n);
        end
        apply();
        #1;
        checks++;
        if ({ARREADY_M2, ARREADY_M1, ARREADY_M0} !== 3'b000 || ARVALID_S !== 1'b0 ||
            grant !== 3'b000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: arready %b arvalid %b grant %b timeout %b exp 000 0 000 0",
                     {ARREADY_M2, ARREADY_M1, ARREADY_M0}, ARVALID_S, grant, timeout);
        end
        checks++;
        if ({ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} !== 49'd0) begin
            errors++;
            $display("FAIL reset_payload: got %h exp 0", {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ptr_m = 0;
    endtask

    task automatic test_round_robin();
        logic [2:0] order[4];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        persist = 1'b1;
        for (int n = 0; n < 3; n++) req[n] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_txn(k % 2, 1);
            checks++;
            if (got_grant !== order[k]) begin
                errors++;
                $display("FAIL rr_order[%0d]: grant %b exp %b", k, got_grant, order[k]);
            end
        end
        persist = 1'b0;
    endtask

    task automatic test_single();
        for (int n = 0; n < 3; n++) req[n] = 1'b0;
        req[1] = 1'b1; id[1] = 4'h3; addr[1] = 32'h0001_0000;
        len[1] = 4'd3; size[1] = 3'd2; burst[1] = 2'd1;
        do_txn(5, 2);
        checks++;
        if (got_grant !== 3'b010) begin
            errors++;
            $display("FAIL single_grant: grant %b exp 010", got_grant);
        end
    endtask

    task automatic test_mid_reset();
        int w;
        for (int n = 0; n < 3; n++) begin
            req[n] = 1'b1;
            new_payload(n);
        end
        w = exp_winner();
        apply();
        @(negedge clk);
        #1;
        checks++;
        if (ARVALID_S !== 1'b1 || grant !== 3'(1 << w)) begin
            errors++;
            $display("FAIL midrst_pre: valid %b grant %b exp 1 %b", ARVALID_S, grant, 3'(1 << w));
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (ARVALID_S !== 1'b0 || grant !== 3'b000 || {ARREADY_M2, ARREADY_M1, ARREADY_M0} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_async: valid %b grant %b arready %b exp 0 000 000", ARVALID_S, grant,
                     {ARREADY_M2, ARREADY_M1, ARREADY_M0});
        end
        @(negedge clk);
        rst = 1'b1;
        ptr_m = 0;
        #1;
        checks++;
        if ({ARREADY_M2, ARREADY_M1, ARREADY_M0} !== 3'b001) begin
            errors++;
            $display("FAIL midrst_ptr: arready %b exp 001", {ARREADY_M2, ARREADY_M1, ARREADY_M0});
        end
        do_txn(1, 1);
    endtask

    task automatic test_id_match();
        for (int n = 0; n < 3; n++) req[n] = 1'b0;
        req[2] = 1'b1;
        new_payload(2);
        force_rid = 8'h05;
        do_txn(0, 1);
        force_rid = -1;
    endtask

    task automatic test_idle();
        for (int n = 0; n < 3; n++) req[n] = 1'b0;
        apply();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({ARREADY_M2, ARREADY_M1, ARREADY_M0} !== 3'b000 || grant !== 3'b000 || ARVALID_S !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: arready %b grant %b valid %b exp 000 000 0",
                         {ARREADY_M2, ARREADY_M1, ARREADY_M0}, grant, ARVALID_S);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            if (!req[0] && !req[1] && !req[2]) begin
                int n;
                n = $urandom_range(0, 2);
                req[n] = 1'b1;
                new_payload(n);
            end
            do_txn($urandom_range(0, 3), $urandom_range(0, 4));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARREADY_S = 1'b0;
        RID_S = 8'h00; RVALID_S = 1'b0; RREADY_S = 1'b0; RLAST_S = 1'b0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_single();
        test_mid_reset();
        test_id_match();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
